// File: rtl/board_move_ctrl.sv
// Board move controller: validates and applies a single-piece move on a 64-square
// board memory, or rewrites the whole board to its start layout.
module board_move_ctrl #(
  parameter logic [3:0] EMPTY_CODE = 4'hC
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MOVE_REQ,
  input  logic [5:0] MOVE_FROM,
  input  logic [5:0] MOVE_TO,
  input  logic       INIT_REQ,
  output logic       READY,
  output logic       DONE,
  output logic [1:0] RESULT,
  output logic [3:0] CAPTURED,
  output logic       BRD_CS,
  output logic       BRD_READ,
  output logic       BRD_WRITE,
  output logic [5:0] BRD_ADDR,
  output logic [3:0] BRD_WRITEDATA,
  input  logic [3:0] BRD_READDATA,
  output logic [3:0] DBG_STATE
);

  // Request handshake: READY is high only in IDLE; a request (INIT_REQ or
  // MOVE_REQ) is taken on any rising edge where READY is high, INIT_REQ winning.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_SRC  = 4'd1,
    LAT_SRC = 4'd2,
    RD_DST  = 4'd3,
    LAT_DST = 4'd4,
    WR_DST  = 4'd5,
    WR_SRC  = 4'd6,
    INIT    = 4'd7,
    FIN     = 4'd8
  } state_t;

  localparam logic [1:0] RES_OK    = 2'b00;
  localparam logic [1:0] RES_SAME  = 2'b01;
  localparam logic [1:0] RES_EMPTY = 2'b10;
  localparam logic [1:0] RES_OWN   = 2'b11;

  state_t     state_q, next_state;
  logic [5:0] from_q, to_q, init_addr_q;
  logic       same_q;
  logic [3:0] src_q;
  logic [1:0] result_q, fin_res;
  logic [3:0] captured_q;
  logic       rd, wr;
  logic [5:0] addr;
  logic [3:0] wdata, init_code;

  always_comb begin
    init_code = EMPTY_CODE;
    case (init_addr_q[5:3])
      3'd0: case (init_addr_q[2:0])
              3'd0, 3'd7: init_code = 4'h6;
              3'd1, 3'd6: init_code = 4'h4;
              3'd2, 3'd5: init_code = 4'h2;
              3'd3:       init_code = 4'h8;
              default:    init_code = 4'hA;
            endcase
      3'd1: init_code = 4'h0;
      3'd6: init_code = 4'h1;
      3'd7: case (init_addr_q[2:0])
              3'd0, 3'd7: init_code = 4'h7;
              3'd1, 3'd6: init_code = 4'h5;
              3'd2, 3'd5: init_code = 4'h3;
              3'd3:       init_code = 4'h9;
              default:    init_code = 4'hB;
            endcase
      default: init_code = EMPTY_CODE;
    endcase
  end

  always_comb begin
    next_state = state_q;
    rd         = 1'b0;
    wr         = 1'b0;
    addr       = 6'd0;
    wdata      = 4'd0;
    fin_res    = RES_OK;
    case (state_q)
      IDLE: begin
        if (INIT_REQ)      next_state = INIT;
        else if (MOVE_REQ) next_state = RD_SRC;
      end
      RD_SRC: begin
        // Same-square moves spend this cycle idle on the bus, then finish.
        if (same_q) begin
          next_state = FIN;
          fin_res    = RES_SAME;
        end else begin
          rd         = 1'b1;
          addr       = from_q;
          next_state = LAT_SRC;
        end
      end
      LAT_SRC: next_state = RD_DST;
      RD_DST: begin
        rd         = 1'b1;
        addr       = to_q;
        next_state = LAT_DST;
      end
      LAT_DST: begin
        if (src_q == EMPTY_CODE) begin
          next_state = FIN;
          fin_res    = RES_EMPTY;
        end else if (BRD_READDATA != EMPTY_CODE && src_q[0] == BRD_READDATA[0]) begin
          next_state = FIN;
          fin_res    = RES_OWN;
        end else begin
          next_state = WR_DST;
        end
      end
      WR_DST: begin
        wr         = 1'b1;
        addr       = to_q;
        wdata      = src_q;
        next_state = WR_SRC;
      end
      WR_SRC: begin
        wr         = 1'b1;
        addr       = from_q;
        wdata      = EMPTY_CODE;
        next_state = FIN;
      end
      INIT: begin
        wr    = 1'b1;
        addr  = init_addr_q;
        wdata = init_code;
        if (init_addr_q == 6'd63) next_state = FIN;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      from_q      <= 6'd0;
      to_q        <= 6'd0;
      same_q      <= 1'b0;
      src_q       <= 4'd0;
      init_addr_q <= 6'd0;
      result_q    <= RES_OK;
      captured_q  <= EMPTY_CODE;
    end else begin
      state_q <= next_state;
      if (state_q == IDLE && (INIT_REQ || MOVE_REQ)) begin
        from_q      <= MOVE_FROM;
        to_q        <= MOVE_TO;
        same_q      <= (MOVE_FROM == MOVE_TO);
        init_addr_q <= 6'd0;
      end
      if (state_q == LAT_SRC) src_q <= BRD_READDATA;
      if (state_q == LAT_DST) captured_q <= BRD_READDATA;
      if (state_q == RD_SRC && same_q) captured_q <= EMPTY_CODE;
      if (state_q == INIT) begin
        init_addr_q <= init_addr_q + 6'd1;
        if (init_addr_q == 6'd63) captured_q <= EMPTY_CODE;
      end
      // RESULT only changes on the transition into FIN, so it holds between completions.
      if (next_state == FIN && state_q != FIN) result_q <= fin_res;
    end
  end

  assign READY         = (state_q == IDLE) && !RESET;
  assign DONE          = (state_q == FIN) && !RESET;
  assign RESULT        = result_q;
  assign CAPTURED      = captured_q;
  assign BRD_READ      = rd && !RESET;
  assign BRD_WRITE     = wr && !RESET;
  assign BRD_CS        = (rd || wr) && !RESET;
  assign BRD_ADDR      = RESET ? 6'd0 : addr;
  assign BRD_WRITEDATA = RESET ? 4'd0 : wdata;
  assign DBG_STATE     = state_q;

endmodule

// File: doc/board_move_ctrl.md
BOARD_MOVE_CTRL -- requirements
Module: board_move_ctrl

Interface
REQ-001 SHALL have parameter EMPTY_CODE, default 4'hC, meaning the square code for an empty square.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MOVE_REQ  input  1  move request valid.
REQ-005 SHALL have port MOVE_FROM  input  6  source square index (row*8+col).
REQ-006 SHALL have port MOVE_TO  input  6  destination square index.
REQ-007 SHALL have port INIT_REQ  input  1  request to rewrite the board to its start layout.
REQ-008 SHALL have port READY  output  1  high only in IDLE; a request is accepted when it is high.
REQ-009 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port RESULT  output  2  completion code: 00 ok, 01 same square, 10 empty source, 11 own-piece capture.
REQ-011 SHALL have port CAPTURED  output  4  destination code read before the move.
REQ-012 SHALL have ports BRD_CS, BRD_READ, BRD_WRITE  output  1 each  board-memory strobes.
REQ-013 SHALL have port BRD_ADDR  output  6  and port BRD_WRITEDATA  output  4  board-memory address and write data.
REQ-014 SHALL have port BRD_READDATA  input  4  board read data, valid one cycle after the read strobe.

Function
REQ-015 SHALL implement states IDLE, RD_SRC, LAT_SRC, RD_DST, LAT_DST, WR_DST, WR_SRC, INIT, FIN.
REQ-016 SHALL accept a request only in IDLE; INIT_REQ has priority when both INIT_REQ and MOVE_REQ are high.
REQ-017 SHALL latch MOVE_FROM and MOVE_TO on acceptance; later input changes have no effect.
REQ-018 SHALL, when MOVE_FROM equals MOVE_TO at acceptance, go directly to FIN with RESULT 01, CAPTURED = EMPTY_CODE, and no bus access.
REQ-019 SHALL otherwise sequence one state per cycle:
  - RD_SRC: CS+READ, addr FROM.
  - LAT_SRC: capture source code.
  - RD_DST: CS+READ, addr TO.
  - LAT_DST: capture destination code into CAPTURED.
  - WR_DST: CS+WRITE, addr TO, data = source code.
  - WR_SRC: CS+WRITE, addr FROM, data = EMPTY_CODE.
  - FIN.
REQ-020 SHALL, in LAT_DST, go to FIN with RESULT 10 and no writes if the source code equals EMPTY_CODE.
REQ-021 SHALL, in LAT_DST, go to FIN with RESULT 11 and no writes if neither code is EMPTY_CODE and their bit 0 values are equal (same colour).
REQ-022 SHALL assert DONE for exactly the FIN cycle, then return to IDLE; RESULT and CAPTURED hold until the next completion.
REQ-023 SHALL, in INIT, write addresses 0..63 in ascending order, one per cycle, with CS+WRITE. Data per square:
  - row 0: 6,4,2,8,A,2,4,6
  - row 1: 0
  - rows 2-5: EMPTY_CODE
  - row 6: 1
  - row 7: 7,5,3,9,B,3,5,7
REQ-024 SHALL go to FIN after the address-63 write, with RESULT 00 and CAPTURED = EMPTY_CODE.
REQ-025 SHALL never assert READ and WRITE in the same cycle, and SHALL drive CS low whenever neither is asserted.
REQ-026 SHALL take 7 cycles from accept edge to DONE for a successful move, 5 for a rejected one, 2 for same-square, and 65 for INIT.

Reset
REQ-027 SHALL, while RESET is high, enter IDLE with these outputs:
  - READY 0 during reset, 1 on the first cycle after release.
  - DONE 0, RESULT 00, CAPTURED = EMPTY_CODE.
  - all BRD_* outputs 0.
REQ-028 SHALL, on RESET mid-sequence, abort without further bus cycles or a DONE pulse; board contents are not restored.

Verification
REQ-029 SHALL verify: INIT_REQ from reset -> 64 writes, addr 0..63, addr 4 data A, addr 20 data C, addr 60 data B; DONE at cycle 65; RESULT 00.
REQ-030 SHALL verify: after init, move 52->36 -> reads 52, 36; writes 36<=1 then 52<=C; DONE at cycle 7; RESULT 00; CAPTURED C.
REQ-031 SHALL verify: after init, move 0->8 -> RESULT 11, CAPTURED 0, no write strobes.
REQ-032 SHALL verify: move 20->28 on an empty square -> RESULT 10, no writes; move 9->9 -> RESULT 01 at cycle 2, no bus activity.
REQ-033 SHALL verify: a capture where destination holds 0 and source holds 9 -> destination <= 9, source <= C, CAPTURED 0, RESULT 00.
REQ-034 SHALL verify: RESET asserted during WR_DST -> next cycle all strobes 0, no DONE, READY 1 after release; simultaneous INIT_REQ+MOVE_REQ -> INIT runs.
